// File: rtl/json_drive_pkg.sv
// json_drive_pkg: shared constants, field type and state enum
// for the JSON drive frame serializer and its field formatter.
package json_drive_pkg;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_T      = 8'h54;
    localparam logic [7:0] CH_L      = 8'h4C;
    localparam logic [7:0] CH_R      = 8'h52;

    localparam int FRAME_LEN_BASE = 27;
    localparam int OFF_T          = 5;
    localparam int OFF_L          = 11;
    localparam int OFF_R          = 21;
    localparam int FIELD_LEN      = 5;

    // Byte i of a speed field is element [i].
    typedef logic [FIELD_LEN-1:0][7:0] field_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

endpackage

// File: rtl/speed_field_fmt.sv
// speed_field_fmt: clamps a signed speed to +/-SPEED_MAX and renders it
// as a 5-byte ASCII field "s0.TU". Ports: i_speed in, o_field out.
module speed_field_fmt
    import json_drive_pkg::*;
#(
    parameter int SPEED_W   = 8,
    parameter int SPEED_MAX = 99
) (
    input  logic signed [SPEED_W-1:0] i_speed,
    output field_t                    o_field
);

    logic signed [31:0] w_wide;
    logic signed [31:0] w_abs;
    logic               w_neg;
    logic [3:0]         w_tens;
    logic [3:0]         w_units;

    always_comb begin
        w_wide = {{(32-SPEED_W){i_speed[SPEED_W-1]}}, i_speed};
        w_neg  = (w_wide < 0);
        if (w_wide > SPEED_MAX) begin
            w_abs = SPEED_MAX;
        end else if (w_wide < -SPEED_MAX) begin
            w_abs = SPEED_MAX;
        end else if (w_neg) begin
            w_abs = -w_wide;
        end else begin
            w_abs = w_wide;
        end
        w_tens  = 4'(w_abs / 10);
        w_units = 4'(w_abs % 10);
        o_field[0] = w_neg ? CH_MINUS : CH_ZERO;
        o_field[1] = CH_ZERO;
        o_field[2] = CH_DOT;
        o_field[3] = CH_ZERO + {4'h0, w_tens};
        o_field[4] = CH_ZERO + {4'h0, w_units};
    end

endmodule

// File: rtl/json_drive_serializer.sv
// json_drive_serializer: formats left/right speed commands into JSON
// drive frames and streams them bytewise. Ports: clk, rst_n, cmd_valid/
// cmd_ready/left_speed/right_speed in, tx_valid/tx_data/tx_ready out,
// busy and cmd_dropped status.
module json_drive_serializer
    import json_drive_pkg::*;
#(
    parameter int SPEED_W          = 8,
    parameter int SPEED_MAX        = 99,
    parameter int APPEND_NL        = 0,
    parameter int KEEPALIVE_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] left_speed,
    input  logic signed [SPEED_W-1:0] right_speed,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      cmd_dropped
);

    localparam int FRAME_LEN = FRAME_LEN_BASE + APPEND_NL;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int KA_W      = (KEEPALIVE_CYCLES > 0) ?
                               $clog2(KEEPALIVE_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [KA_W-1:0]  KA_MAX   = KA_W'(KEEPALIVE_CYCLES);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_cmd_ready;
    logic                      r_pend_valid;
    logic                      r_drop;
    logic signed [SPEED_W-1:0] r_pend_l;
    logic signed [SPEED_W-1:0] r_pend_r;
    logic signed [SPEED_W-1:0] r_last_l;
    logic signed [SPEED_W-1:0] r_last_r;
    logic signed [SPEED_W-1:0] w_src_l;
    logic signed [SPEED_W-1:0] w_src_r;
    logic [KA_W-1:0]           r_ka;
    logic [IDX_W-1:0]          r_idx;
    logic [7:0]                r_frame [FRAME_LEN];
    logic [7:0]                w_frame [FRAME_LEN];
    field_t                    w_fld_l;
    field_t                    w_fld_r;
    logic                      w_acc;
    logic                      w_ka_fire;
    logic                      w_byte_acc;
    logic                      w_last_byte;

    assign w_acc       = cmd_valid & r_cmd_ready;
    assign w_ka_fire   = (KEEPALIVE_CYCLES != 0) && (r_ka == KA_MAX);
    assign w_byte_acc  = (r_state == SEND) && tx_ready;
    assign w_last_byte = w_byte_acc && (r_idx == IDX_LAST);

    // A keepalive load finds the slot empty and re-sends the last values.
    assign w_src_l = r_pend_valid ? r_pend_l : r_last_l;
    assign w_src_r = r_pend_valid ? r_pend_r : r_last_r;

    speed_field_fmt #(.SPEED_W(SPEED_W), .SPEED_MAX(SPEED_MAX)) u_fmt_l (
        .i_speed (w_src_l),
        .o_field (w_fld_l)
    );

    speed_field_fmt #(.SPEED_W(SPEED_W), .SPEED_MAX(SPEED_MAX)) u_fmt_r (
        .i_speed (w_src_r),
        .o_field (w_fld_r)
    );

    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            w_frame[i] = 8'h00;
        end
        w_frame[0]  = CH_LBRACE;
        w_frame[1]  = CH_QUOTE;
        w_frame[2]  = CH_T;
        w_frame[3]  = CH_QUOTE;
        w_frame[4]  = CH_COLON;
        w_frame[OFF_T] = (w_src_l == 0 && w_src_r == 0) ?
                         CH_ZERO : CH_ZERO + 8'd1;
        w_frame[6]  = CH_COMMA;
        w_frame[7]  = CH_QUOTE;
        w_frame[8]  = CH_L;
        w_frame[9]  = CH_QUOTE;
        w_frame[10] = CH_COLON;
        w_frame[16] = CH_COMMA;
        w_frame[17] = CH_QUOTE;
        w_frame[18] = CH_R;
        w_frame[19] = CH_QUOTE;
        w_frame[20] = CH_COLON;
        for (int i = 0; i < FIELD_LEN; i++) begin
            w_frame[OFF_L+i] = w_fld_l[i];
            w_frame[OFF_R+i] = w_fld_r[i];
        end
        w_frame[FRAME_LEN_BASE-1] = CH_RBRACE;
        if (APPEND_NL != 0) begin
            w_frame[FRAME_LEN-1] = CH_LF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (r_pend_valid || w_ka_fire) w_state_nxt = LOAD;
            LOAD: w_state_nxt = SEND;
            SEND: if (w_last_byte) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_valid    = (r_state == SEND);
        tx_data     = tx_valid ? r_frame[r_idx] : 8'h00;
        busy        = (r_state != IDLE);
        cmd_ready   = r_cmd_ready;
        cmd_dropped = r_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_drop       <= 1'b0;
            r_pend_l     <= '0;
            r_pend_r     <= '0;
            r_last_l     <= '0;
            r_last_r     <= '0;
            r_ka         <= '0;
            r_idx        <= '0;
        end else begin
            r_cmd_ready <= 1'b1;
            // Overwrite in LOAD is not a drop: the old value is being sent.
            r_drop <= w_acc && r_pend_valid && (r_state != LOAD);
            if (w_acc) begin
                r_pend_valid <= 1'b1;
                r_pend_l     <= left_speed;
                r_pend_r     <= right_speed;
            end else if (r_state == LOAD) begin
                r_pend_valid <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_last_l <= w_src_l;
                r_last_r <= w_src_r;
                r_idx    <= '0;
            end else if (w_byte_acc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state != IDLE || w_acc) begin
                r_ka <= '0;
            end else if (!r_pend_valid && r_ka != KA_MAX) begin
                r_ka <= r_ka + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_frame[i] <= 8'h00;
            end
        end else if (r_state == LOAD) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_frame[i] <= w_frame[i];
            end
        end
    end

endmodule
